// File: rtl/simon_interface.sv
// Bus-mapped Simon 128/128 encryptor: PT/KEY/CT/CSR register file around an
// iterative core that runs one round per clock with an on-the-fly key schedule.
module simon_interface #(
  parameter int ROUNDS = 68
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_i,
  input  logic [3:0]  we_i,
  input  logic [7:0]  addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o
);
  localparam int CW = $clog2(ROUNDS);
  // z2 sequence, index 0 is the leftmost character
  localparam logic [0:61] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;

  logic [3:0][31:0] pt_q, key_q, ct_q;
  logic [63:0]      x_q, y_q, ka_q, kb_q;  // ka = k_i, kb = k_{i+1}
  logic [CW-1:0]    rnd_q;
  logic [5:0]       z_q;
  logic             busy_q, valid_q;

  logic [5:0]  word;
  logic        wr, rd, start;
  logic [63:0] fx, x_nxt, k_nxt;
  logic [31:0] rdata;
  logic        unused_addr;

  function automatic logic [63:0] rotl(input logic [63:0] v, input int unsigned n);
    return (v << n) | (v >> (64 - n));
  endfunction

  function automatic logic [63:0] rotr(input logic [63:0] v, input int unsigned n);
    return (v >> n) | (v << (64 - n));
  endfunction

  function automatic logic [31:0] bmerge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  assign word        = addr_i[7:2];
  assign unused_addr = ^addr_i[1:0];
  assign wr          = en_i && (we_i != 4'b0000);
  assign rd          = en_i && (we_i == 4'b0000);
  assign start       = wr && (word == 6'd12) && we_i[0] && data_i[0] && !busy_q;

  assign fx    = (rotl(x_q, 1) & rotl(x_q, 8)) ^ rotl(x_q, 2);
  assign x_nxt = y_q ^ fx ^ ka_q;
  // ~k ^ 3 folds the constant c = 2^64 - 4 into the schedule
  assign k_nxt = ~ka_q ^ rotr(kb_q, 3) ^ rotr(kb_q, 4) ^ {63'd0, Z2[z_q]} ^ 64'd3;

  always_comb begin
    rdata = '0;
    case (word[5:2])
      4'd0: rdata = pt_q[word[1:0]];
      4'd1: rdata = key_q[word[1:0]];
      4'd2: rdata = ct_q[word[1:0]];
      4'd3: if (word[1:0] == 2'd0) rdata = {30'd0, valid_q, busy_q};
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pt_q    <= '0;
      key_q   <= '0;
      ct_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      ka_q    <= '0;
      kb_q    <= '0;
      rnd_q   <= '0;
      z_q     <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      data_o  <= '0;
    end else begin
      if (wr && word[5:3] == 3'd0) begin
        if (!word[2]) pt_q[word[1:0]]  <= bmerge(pt_q[word[1:0]], data_i, we_i);
        else          key_q[word[1:0]] <= bmerge(key_q[word[1:0]], data_i, we_i);
      end

      if (start) begin
        x_q     <= {pt_q[0], pt_q[1]};
        y_q     <= {pt_q[2], pt_q[3]};
        kb_q    <= {key_q[0], key_q[1]};
        ka_q    <= {key_q[2], key_q[3]};
        rnd_q   <= '0;
        z_q     <= '0;
        busy_q  <= 1'b1;
        valid_q <= 1'b0;
      end else if (busy_q) begin
        x_q   <= x_nxt;
        y_q   <= x_q;
        ka_q  <= kb_q;
        kb_q  <= k_nxt;
        rnd_q <= rnd_q + 1'b1;
        z_q   <= (z_q == 6'd61) ? 6'd0 : z_q + 6'd1;
        if (rnd_q == CW'(ROUNDS - 1)) begin
          ct_q[0] <= x_nxt[63:32];
          ct_q[1] <= x_nxt[31:0];
          ct_q[2] <= x_q[63:32];
          ct_q[3] <= x_q[31:0];
          busy_q  <= 1'b0;
          valid_q <= 1'b1;
        end
      end

      if (rd) data_o <= rdata;
    end
  end
endmodule

// File: tb/tb_simon_interface.sv
// Scoreboarded bench for simon_interface: reads push expected words, a monitor
// compares data_o the cycle after each read against a plain Simon reference.
module tb_simon_interface;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en_i = 1'b0;
  logic [3:0]  we_i = 4'h0;
  logic [7:0]  addr_i = 8'h00;
  logic [31:0] data_i = 32'h0;
  logic [31:0] data_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  string       nm_q[$];
  logic        rd_seen;

  simon_interface #(.ROUNDS(68)) dut (
    .clk(clk), .rst_n(rst_n), .en_i(en_i), .we_i(we_i),
    .addr_i(addr_i), .data_i(data_i), .data_o(data_o)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [63:0] rl(input logic [63:0] v, input int n);
    return (v << n) | (v >> (64 - n));
  endfunction

  function automatic logic [127:0] simon_ref(input logic [127:0] pt, input logic [127:0] key);
    logic [63:0] k[68];
    logic [63:0] x, y, t;
    logic [61:0] z;
    z = 62'b10101111011100000011010010011000101000010001111110010110110011;
    k[0] = key[63:0];
    k[1] = key[127:64];
    for (int i = 0; i < 66; i++)
      k[i+2] = ~k[i] ^ rl(k[i+1], 61) ^ rl(k[i+1], 60) ^ {63'd0, z[61 - (i % 62)]} ^ 64'd3;
    x = pt[127:64];
    y = pt[63:0];
    for (int i = 0; i < 68; i++) begin
      t = x;
      x = y ^ ((rl(x, 1) & rl(x, 8)) ^ rl(x, 2)) ^ k[i];
      y = t;
    end
    return {x, y};
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", n, act, exp);
    end
  endtask

  always @(posedge clk or negedge rst_n)
    if (!rst_n) rd_seen <= 1'b0;
    else        rd_seen <= en_i && (we_i == 4'h0);

  always @(negedge clk) begin
    logic [31:0] e;
    string       n;
    if (rd_seen) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_read got %h expected none", data_o);
      end else begin
        e = exp_q.pop_front();
        n = nm_q.pop_front();
        check(n, data_o, e);
      end
    end
  end

  // ---------------- bus driver ----------------
  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    en_i = 1'b1; we_i = be; addr_i = a; data_i = d;
    @(posedge clk); #1;
    en_i = 1'b0; we_i = 4'h0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] e, input string n);
    exp_q.push_back(e);
    nm_q.push_back(n);
    en_i = 1'b1; we_i = 4'h0; addr_i = a;
    @(posedge clk); #1;
    en_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [127:0] pt, input logic [127:0] key);
    for (int i = 0; i < 4; i++) begin
      wr(8'(4*i), pt[127-32*i -: 32], 4'hF);
      wr(8'(16 + 4*i), key[127-32*i -: 32], 4'hF);
    end
  endtask

  task automatic go();
    wr(8'h30, 32'h1, 4'h1);
  endtask

  task automatic rd_ct(input logic [127:0] e, input string n);
    for (int i = 0; i < 4; i++) rd(8'(32 + 4*i), e[127-32*i -: 32], n);
  endtask

  // ---------------- stimulus ----------------
  localparam logic [127:0] STD_PT  = 128'h63736564_20737265_6C6C6576_61727420;
  localparam logic [127:0] STD_KEY = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
  localparam logic [127:0] STD_CT  = 128'h49681B1E_1E54FE3F_65AA832A_F84E0BBC;
  localparam logic [127:0] SEQ     = 128'h74636364_616E6965_6C31322F_32303234;

  initial begin
    logic [31:0]  m[8];
    logic [127:0] pt, key, res;
    int           idx;
    logic [3:0]   be;
    logic [31:0]  d;

    idle(3);
    rst_n = 1'b1;
    idle(1);
    check("reset_data_o", data_o, 32'h0);
    rd(8'h30, 32'h0, "reset_csr");
    rd(8'h20, 32'h0, "reset_ct0");
    rd(8'h00, 32'h0, "reset_pt0");
    rd(8'h1C, 32'h0, "reset_key3");

    // byte enables, read-only CT, unmapped space, non-start CSR writes
    wr(8'h04, 32'h0, 4'hF);
    wr(8'h04, 32'hFFFF_FFFF, 4'b0011);
    rd(8'h04, 32'h0000_FFFF, "byte_enable");
    wr(8'h20, 32'hDEAD_BEEF, 4'hF);
    rd(8'h20, 32'h0, "ct_write_ignored");
    rd(8'h34, 32'h0, "unmapped_0x34");
    wr(8'h30, 32'h0, 4'h1);
    rd(8'h30, 32'h0, "csr_bit0_zero");
    wr(8'h30, 32'h1, 4'b0010);
    rd(8'h30, 32'h0, "csr_no_we0");

    // standard vector with exact latency: busy for 68 read cycles, then valid
    load(STD_PT, STD_KEY);
    rd(8'h0C, 32'h6172_7420, "pt3_readback");
    rd(8'h10, 32'h0F0E_0D0C, "key0_readback");
    go();
    for (int i = 0; i < 68; i++) rd(8'h30, 32'h1, "std_busy");
    rd(8'h30, 32'h2, "std_valid");
    rd_ct(STD_CT, "std_ct");

    // restart while valid, then ignored start and PT rewrite mid-run
    go();
    rd(8'h30, 32'h1, "restart_valid_drop");
    wr(8'h00, 32'h1234_5678, 4'hF);
    go();
    idle(10);
    rd(8'h30, 32'h1, "csr_midrun");
    rd(8'h20, STD_CT[127:96], "ct_holds_prev");
    rd(8'h00, 32'h1234_5678, "pt_rewrite_midrun");
    idle(70);
    rd(8'h30, 32'h2, "busy_run_valid");
    rd_ct(STD_CT, "busy_run_ct");

    // sequential run on a second vector
    load(SEQ, SEQ);
    go();
    rd(8'h30, 32'h1, "seq_valid_drop");
    idle(66);
    rd(8'h30, 32'h1, "seq_busy_last");
    rd(8'h30, 32'h2, "seq_valid");
    rd_ct(simon_ref(SEQ, SEQ), "seq_ct");

    // randomized runs with partial writes and ignored writes
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 8; i++) begin
        m[i] = $urandom;
        wr(8'(4*i), m[i], 4'hF);
      end
      for (int j = 0; j < 4; j++) begin
        idx = $urandom_range(0, 7);
        be  = 4'($urandom_range(1, 15));
        d   = $urandom;
        wr(8'(4*idx + $urandom_range(0, 3)), d, be);
        for (int b = 0; b < 4; b++) if (be[b]) m[idx][8*b +: 8] = d[8*b +: 8];
      end
      wr(8'(32 + 4*$urandom_range(0, 3)), $urandom, 4'hF);
      wr(8'(4*$urandom_range(13, 63)), $urandom, 4'hF);
      idx = $urandom_range(0, 7);
      rd(8'(4*idx), m[idx], "rand_readback");
      rd(8'(4*$urandom_range(13, 63) + $urandom_range(0, 3)), 32'h0, "rand_unmapped");
      pt  = {m[0], m[1], m[2], m[3]};
      key = {m[4], m[5], m[6], m[7]};
      res = simon_ref(pt, key);
      go();
      idle(70);
      rd(8'h30, 32'h2, "rand_valid");
      rd_ct(res, "rand_ct");
    end

    // asynchronous reset mid-operation
    go();
    idle(20);
    rd(8'h20, res[127:96], "pre_reset_ct0");
    idle(3);
    rst_n = 1'b0;
    #2;
    check("midrun_reset_data_o", data_o, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);
    rd(8'h30, 32'h0, "post_reset_csr");
    rd_ct(128'h0, "post_reset_ct");
    rd(8'h08, 32'h0, "post_reset_pt2");
    rd(8'h14, 32'h0, "post_reset_key1");
    idle(80);
    rd(8'h30, 32'h0, "post_reset_no_run");

    idle(3);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout got running expected finished");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/simon_interface.md
Name: simon_interface

Overview:
- Memory-mapped peripheral wrapping an iterative Simon 128/128 block-cipher encryptor (64-bit words, 2-word key, 68 rounds).
- The host bus writes plaintext and key words, starts encryption through a CSR, polls a valid flag, and reads back the 128-bit ciphertext.
- It sits on a simple 32-bit enable/byte-write-enable slave bus.

Parameters:
- ROUNDS, 68, number of Simon rounds (fixed for 128/128; not intended to be changed).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- en_i  input  1  bus access enable
- we_i  input  4  byte write enables; we_i[b] writes data_i[8b+7:8b]; 0000 = read
- addr_i  input  8  byte address; word select = addr_i[7:2], addr_i[1:0] ignored
- data_i  input  32  write data
- data_o  output  32  read data (registered)

Behaviour:
- Register map (word 0 = most significant 32 bits of each 128-bit value):
  - 0x00–0x0C PT_0..PT_3, R/W. Plaintext: x = {PT_0,PT_1}, y = {PT_2,PT_3}.
  - 0x10–0x1C KEY_0..KEY_3, R/W. k1 = {KEY_0,KEY_1}, k0 = {KEY_2,KEY_3}.
  - 0x20–0x2C CT_0..CT_3, read-only. Ciphertext {x,y} after the final round.
  - 0x30 CSR. Write bit0 = start (self-clearing, not stored). Read bit0 = busy, bit1 = valid, bits 31:2 = 0.
  - Other addresses: reads return 0, writes are ignored.
- Writes:
  - Occur when en_i=1 and any we_i bit is set; per-byte masking applies.
  - Writes to CT are ignored.
- Reads:
  - Occur when en_i=1 and we_i=0000.
  - data_o is loaded on the rising edge with the addressed word (one-cycle latency).
  - data_o holds its value when en_i=0 or during writes.
- Start:
  - Triggered by a CSR write with we_i[0]=1 and data_i[0]=1, only while not busy.
  - A start while busy is ignored.
  - On start: latch x, y, k0, k1 from PT/KEY into internal state; busy=1, valid=0, round counter=0.
- Core, one round per cycle:
  - Round: x' = y ^ f(x) ^ k_i, y' = x, where f(x) = (rotl(x,1) & rotl(x,8)) ^ rotl(x,2).
  - Key schedule (m=2), generated on the fly: tmp = rotr(k_{i+1},3) ^ rotr(k_{i+1},4); k_{i+2} = ~k_i ^ tmp ^ z2[i mod 62] ^ 3. Equivalently c = 0xFFFF_FFFF_FFFF_FFFC.
  - The z2 bit is XORed into bit 0. z2 = 10101111011100000011010010011000101000010001111110010110110011, with bit index 0 as the leftmost character.
  - Rounds use k_0..k_67.
- Completion:
  - After 68 round cycles, CT_0..3 <= {x,y}; busy=0, valid=1 on the same edge.
  - valid stays 1 until the next accepted start.
  - Latency from the start edge to valid=1 is 68 clocks (CSR read shows it one clock later).
- PT/KEY may be rewritten while busy. This does not affect the running operation (inputs are latched at start).
- CT holds the previous result until the new one completes.
- Reset (asynchronous, also mid-operation): all PT/KEY/CT/internal state = 0, busy=0, valid=0, data_o=0, counter=0.
- Back-to-back operations: a new start after valid=1 re-runs cleanly, with no stale key-schedule state.

Test Plan:
- Reset value: assert rst_n=0 mid-operation -> data_o=0; CSR reads 0x0; CT reads 0.
- Standard vector:
  - Stimulus: KEY_0..3 = 0F0E0D0C, 0B0A0908, 07060504, 03020100; PT_0..3 = 63736564, 20737265, 6C6C6576, 61727420; start.
  - Response: valid after 68 clocks; CT_0..3 = 49681B1E, 1E54FE3F, 65AA832A, F84E0BBC.
- Byte enables: write PT_1 = FFFFFFFF with we=0011 over 00000000 -> read 0000FFFF; CT write has no effect.
- Busy behaviour:
  - Stimulus: start, then read CSR during the run; issue a second start and rewrite PT mid-run.
  - Response: CSR = 0x1 during the run; the result equals the standard vector; the second start is ignored.
- Sequential run:
  - Stimulus: after the first result, load PT and KEY = 74636364, 616E6965, 6C31322F, 32303234 and start.
  - Response: valid drops to 0 on start and returns after 68 clocks; the result matches the software Simon 128/128 model.
- Unmapped address: read 0x34 -> 0; CSR write with data bit0=0 -> no start.
